waveform_generator_param: RTL and testbench

Parametrised, programmable-period waveform generator that produces square, triangle, sawtooth and reverse-sawtooth samples on a DATA_W-bit bus.
It extends the fixed 8-bit, fixed-127-cycle generator with:
- a programmable half-period;
- double-buffered configuration, applied glitch-free at period boundaries;
- enable/freeze;
- a period-start strobe.

It sits between the function-select front end and the DAC/output stage.

---
 rtl/wavegen_pkg.sv | 24 ++
 rtl/waveform_generator_param_if.sv | 31 +++
 rtl/wavegen_phase_ctr.sv | 49 ++++
 rtl/waveform_generator_param.sv | 94 +++++++++
 tb/tb_waveform_generator_param.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wavegen_pkg.sv
// Shared definitions for the parametrised waveform generator.
//   func_e       : function-select encodings (any other 3-bit code mutes the output)
//   SAT_W        : working width of the saturating conversion helper
//   sat_unsigned : clamps an unsigned value to the largest value that fits in out_w bits
package wavegen_pkg;

    typedef enum logic [2:0] {
        FUNC_SAW    = 3'b000,
        FUNC_SQUARE = 3'b001,
        FUNC_RSAW   = 3'b010,
        FUNC_TRI    = 3'b011
    } func_e;

    // Raw samples are PHASE_W+2 bits wide, so PHASE_W must stay below 31.
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_unsigned(input logic [SAT_W-1:0] v,
                                                      input int unsigned       out_w);
        logic [SAT_W-1:0] maxv;
        maxv = (out_w >= SAT_W) ? '1 : ((SAT_W'(1) << out_w) - SAT_W'(1));
        return (v > maxv) ? maxv : v;
    endfunction

endpackage

// File: rtl/waveform_generator_param_if.sv
// Control/sample bundle between the function-select front end and the generator.
//   en           : advance phase (0 freezes the generator)
//   func         : requested function code
//   half_period  : requested half-period H (cycles per half = max(H,1)+1)
//   cfg_load     : one-cycle strobe capturing func/half_period into the shadow
//   cfg_pending  : shadow captured but not yet active
//   period_start : one-cycle pulse after each period end
//   wave_out     : registered output sample
// master = front end, slave = generator.
interface waveform_generator_param_if #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 8
);
    logic               en;
    logic [2:0]         func;
    logic [PHASE_W-1:0] half_period;
    logic               cfg_load;
    logic               cfg_pending;
    logic               period_start;
    logic [DATA_W-1:0]  wave_out;

    modport master (
        output en, func, half_period, cfg_load,
        input  cfg_pending, period_start, wave_out
    );

    modport slave (
        input  en, func, half_period, cfg_load,
        output cfg_pending, period_start, wave_out
    );
endinterface

// File: rtl/wavegen_phase_ctr.sv
// Phase counter for the waveform generator: phase ph walks 0..Heff in each half,
// seg selects the half, and period_end flags the enabled edge closing a period.
//   clk, rst_n : clock, async active-low reset
//   en         : advance phase when high, hold otherwise
//   half       : active half-period H (0 is treated as 1)
//   ph, seg    : current phase and segment
//   heff       : clamped half-period max(H,1)
//   period_end : high when the next enabled edge ends the period
//
// seg | meaning
// ----+--------------------------
//  0  | first half of the period
//  1  | second half of the period
module wavegen_phase_ctr
    import wavegen_pkg::*;
#(
    parameter int PHASE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] half,
    output logic [PHASE_W-1:0] ph,
    output logic [PHASE_W-1:0] heff,
    output logic               seg,
    output logic               period_end
);

    logic at_top;

    assign heff       = (half == '0) ? PHASE_W'(1) : half;
    assign at_top     = (ph == heff);
    assign period_end = en & at_top & seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph  <= '0;
            seg <= 1'b0;
        end else if (en) begin
            if (at_top) begin
                ph  <= '0;
                seg <= ~seg;
            end else begin
                ph <= ph + 1'b1;
            end
        end
    end

endmodule

// File: rtl/waveform_generator_param.sv
// Programmable waveform generator: square, triangle, sawtooth and reverse sawtooth
// samples with a double-buffered func/half-period that switches only at period ends.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of waveform_generator_param_if (controls, strobe, sample)
module waveform_generator_param
    import wavegen_pkg::*;
#(
    parameter int         DATA_W     = 8,
    parameter int         PHASE_W    = 8,
    parameter int         RESET_HALF = 127,
    parameter logic [2:0] RESET_FUNC = 3'b001
) (
    input logic                       clk,
    input logic                       rst_n,
    waveform_generator_param_if.slave bus
);

    localparam int VW = PHASE_W + 2;

    logic [2:0]         active_func, shadow_func;
    logic [PHASE_W-1:0] active_half, shadow_half;
    logic               pending_q, start_q;
    logic [DATA_W-1:0]  wave_q;

    logic [PHASE_W-1:0] ph, heff;
    logic               seg, period_end;

    logic [VW-1:0]      ph_w, heff_w, lin, v;
    logic [DATA_W-1:0]  sample;

    wavegen_phase_ctr #(.PHASE_W(PHASE_W)) u_phase (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (bus.en),
        .half       (active_half),
        .ph         (ph),
        .heff       (heff),
        .seg        (seg),
        .period_end (period_end)
    );

    // lin is the position within the full period, the common base of both saw shapes.
    always_comb begin
        ph_w   = VW'(ph);
        heff_w = VW'(heff);
        lin    = (seg ? heff_w + VW'(1) : '0) + ph_w;
        v      = '0;
        case (active_func)
            FUNC_SAW:  v = lin;
            FUNC_RSAW: v = (heff_w << 1) + VW'(1) - lin;
            FUNC_TRI:  v = seg ? (heff_w - ph_w) : ph_w;
            default:   v = '0;
        endcase
        sample = DATA_W'(sat_unsigned(SAT_W'(v), DATA_W));
        // Square is full scale regardless of phase width, so it bypasses the clamp.
        if (active_func == FUNC_SQUARE) sample = {DATA_W{seg}};
    end

    // The apply at period end reads the shadow before a same-cycle cfg_load lands,
    // and the later cfg_pending assignment keeps the new shadow marked pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_func <= RESET_FUNC;
            active_half <= PHASE_W'(RESET_HALF);
            shadow_func <= RESET_FUNC;
            shadow_half <= PHASE_W'(RESET_HALF);
            pending_q   <= 1'b0;
            start_q     <= 1'b0;
            wave_q      <= '0;
        end else begin
            if (period_end && pending_q) begin
                active_func <= shadow_func;
                active_half <= shadow_half;
                pending_q   <= 1'b0;
            end
            if (bus.cfg_load) begin
                shadow_func <= bus.func;
                shadow_half <= bus.half_period;
                pending_q   <= 1'b1;
            end
            if (bus.en) begin
                start_q <= period_end;
                wave_q  <= sample;
            end else begin
                start_q <= 1'b0;
            end
        end
    end

    assign bus.cfg_pending  = pending_q;
    assign bus.period_start = start_q;
    assign bus.wave_out     = wave_q;

endmodule

// File: tb/tb_waveform_generator_param.sv
// Self-checking bench: a period-index reference model predicts every sample,
// strobe and pending flag; scenario tasks add fixed-sequence checks on top.
module tb_waveform_generator_param;

    localparam int DW   = 8;
    localparam int PW   = 8;
    localparam int MAXV = (1 << DW) - 1;

    logic clk;
    logic rst_n;

    waveform_generator_param_if #(.DATA_W(DW), .PHASE_W(PW)) bus_if ();

    waveform_generator_param #(
        .DATA_W(DW), .PHASE_W(PW), .RESET_HALF(127), .RESET_FUNC(3'b001)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position t within the period plus active/shadow config.
    int          m_t, m_func, m_h, s_func, s_h;
    bit          m_pend;
    logic [DW-1:0] exp_wave;
    bit          exp_ps;

    function automatic int heff_of(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic int ref_sample(input int f, input int h, input int t);
        int he, len, off, v;
        bit sg;
        he  = heff_of(h);
        len = he + 1;
        sg  = (t >= len);
        off = sg ? t - len : t;
        case (f)
            0: v = t;
            1: return sg ? MAXV : 0;
            2: v = 2 * he + 1 - t;
            3: v = sg ? he - off : off;
            default: v = 0;
        endcase
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic model_reset();
        m_t = 0; m_func = 1; m_h = 127; s_func = 1; s_h = 127;
        m_pend = 0; exp_wave = '0; exp_ps = 0;
    endtask

    task automatic step(input bit e, input int f, input int h, input bit ld);
        int plen;
        bit pend_end;
        bus_if.en          = e;
        bus_if.func        = 3'(f);
        bus_if.half_period = PW'(h);
        bus_if.cfg_load    = ld;
        @(posedge clk);
        if (e) begin
            plen     = 2 * (heff_of(m_h) + 1);
            exp_wave = DW'(ref_sample(m_func, m_h, m_t));
            pend_end = (m_t == plen - 1);
            exp_ps   = pend_end;
            m_t      = pend_end ? 0 : m_t + 1;
            if (pend_end && m_pend) begin
                m_func = s_func; m_h = s_h; m_pend = 0;
            end
        end else begin
            exp_ps = 0;
        end
        if (ld) begin
            s_func = f & 7; s_h = h & ((1 << PW) - 1); m_pend = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.en = 1'b0; bus_if.func = 3'b000; bus_if.half_period = '0; bus_if.cfg_load = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (bus_if.wave_out !== 8'd0) begin errors++; $display("FAIL reset_wave got %0d exp 0", bus_if.wave_out); end
        if (bus_if.period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got %0b exp 0", bus_if.period_start); end
        if (bus_if.cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %0b exp 0", bus_if.cfg_pending); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_square_default();
        logic [DW-1:0] cw;
        for (int k = 0; k < 520; k++) begin
            step(1, 0, 0, 0);
            cw = ((k % 256) < 128) ? 8'd0 : 8'd255;
            checks += 5;
            if (bus_if.wave_out !== exp_wave) begin errors++; $display("FAIL sq_wave k=%0d got %0d exp %0d", k, bus_if.wave_out, exp_wave); end
            if (bus_if.wave_out !== cw) begin errors++; $display("FAIL sq_const k=%0d got %0d exp %0d", k, bus_if.wave_out, cw); end
            if (bus_if.period_start !== exp_ps) begin errors++; $display("FAIL sq_ps k=%0d got %0b exp %0b", k, bus_if.period_start, exp_ps); end
            if (bus_if.period_start !== ((k % 256) == 255)) begin errors++; $display("FAIL sq_ps_const k=%0d got %0b", k, bus_if.period_start); end
            if (bus_if.cfg_pending !== m_pend) begin errors++; $display("FAIL sq_pending k=%0d got %0b exp %0b", k, bus_if.cfg_pending, m_pend); end
        end
    endtask

    // Loads a config, runs until the model applies it, then checks one fixed pattern.
    task automatic test_pattern(input string name, input int f, input int h,
                                input int pat[], input int n_after);
        int guard;
        step(1, f, h, 1);
        guard = 0;
        while (m_pend && guard < 2000) begin
            step(1, 0, 0, 0);
            guard++;
            checks += 3;
            if (bus_if.wave_out !== exp_wave) begin errors++; $display("FAIL %s_pre_wave got %0d exp %0d", name, bus_if.wave_out, exp_wave); end
            if (bus_if.period_start !== exp_ps) begin errors++; $display("FAIL %s_pre_ps got %0b exp %0b", name, bus_if.period_start, exp_ps); end
            if (bus_if.cfg_pending !== m_pend) begin errors++; $display("FAIL %s_pre_pending got %0b exp %0b", name, bus_if.cfg_pending, m_pend); end
        end
        checks++;
        if (m_pend || bus_if.period_start !== 1'b1) begin
            errors++; $display("FAIL %s_apply ps=%0b pending=%0b exp ps=1 pending=0", name, bus_if.period_start, bus_if.cfg_pending);
        end
        for (int j = 0; j < n_after; j++) begin
            step(1, 0, 0, 0);
            checks += 4;
            if (bus_if.wave_out !== exp_wave) begin errors++; $display("FAIL %s_wave j=%0d got %0d exp %0d", name, j, bus_if.wave_out, exp_wave); end
            if (bus_if.wave_out !== DW'(pat[j % pat.size()])) begin errors++; $display("FAIL %s_seq j=%0d got %0d exp %0d", name, j, bus_if.wave_out, pat[j % pat.size()]); end
            if (bus_if.period_start !== exp_ps) begin errors++; $display("FAIL %s_ps j=%0d got %0b exp %0b", name, j, bus_if.period_start, exp_ps); end
            if (bus_if.cfg_pending !== 1'b0) begin errors++; $display("FAIL %s_pending j=%0d got %0b exp 0", name, j, bus_if.cfg_pending); end
        end
    endtask

    task automatic test_functions();
        int p_tri[]  = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};
        int p_saw[]  = new[402];
        int p_rsaw[] = '{7, 6, 5, 4, 3, 2, 1, 0};
        int p_h0[]   = '{0, 1, 1, 0};
        int p_mute[] = '{0};
        for (int i = 0; i < 402; i++) p_saw[i] = (i > 255) ? 255 : i;
        test_pattern("tri", 3, 4, p_tri, 30);
        test_pattern("saw", 0, 200, p_saw, 410);
        test_pattern("rsaw", 2, 3, p_rsaw, 24);
        test_pattern("h0", 3, 0, p_h0, 16);
        test_pattern("mute", 7, 2, p_mute, 12);
    endtask

    task automatic test_mute_strobe();
        int pulses = 0;
        for (int j = 0; j < 12; j++) begin
            step(1, 0, 0, 0);
            if (bus_if.period_start === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL mute_pulses got %0d exp 2", pulses); end
    endtask

    task automatic test_freeze();
        logic [DW-1:0] held;
        int p_saw9[] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
        int p_tri5[] = '{0, 1, 2, 3, 4, 5, 5, 4, 3, 2, 1, 0};
        test_pattern("frz_saw", 0, 9, p_saw9, 7);
        held = exp_wave;
        for (int j = 0; j < 10; j++) begin
            step(0, 3, 5, j == 3);
            checks += 3;
            if (bus_if.wave_out !== held) begin errors++; $display("FAIL frz_hold j=%0d got %0d exp %0d", j, bus_if.wave_out, held); end
            if (bus_if.period_start !== 1'b0) begin errors++; $display("FAIL frz_ps j=%0d got %0b exp 0", j, bus_if.period_start); end
            if (bus_if.cfg_pending !== m_pend) begin errors++; $display("FAIL frz_pending j=%0d got %0b exp %0b", j, bus_if.cfg_pending, m_pend); end
        end
        // First enabled edge continues where the phase froze.
        step(1, 0, 0, 0);
        checks++;
        if (bus_if.wave_out !== 8'd7) begin errors++; $display("FAIL frz_resume got %0d exp 7", bus_if.wave_out); end
        // Load already pending from the frozen window; re-issue it so the shared task can follow it.
        test_pattern("frz_tri", 3, 5, p_tri5, 24);
    endtask

    task automatic test_cfg_at_period_end();
        int guard = 0;
        int p_saw3[] = '{0, 1, 2, 3, 4, 5, 6, 7};
        step(1, 3, 2, 1);
        while (m_t != 2 * (heff_of(m_h) + 1) - 1 && guard < 1000) begin
            step(1, 0, 0, 0);
            guard++;
        end
        step(1, 0, 3, 1);
        checks += 3;
        if (bus_if.period_start !== 1'b1) begin errors++; $display("FAIL pe_ps got %0b exp 1", bus_if.period_start); end
        if (bus_if.cfg_pending !== 1'b1) begin errors++; $display("FAIL pe_pending got %0b exp 1", bus_if.cfg_pending); end
        if (m_func != 3 || m_h != 2) begin errors++; $display("FAIL pe_model_func got %0d/%0d exp 3/2", m_func, m_h); end
        for (int j = 0; j < 6; j++) begin
            step(1, 0, 0, 0);
            checks += 2;
            if (bus_if.wave_out !== exp_wave) begin errors++; $display("FAIL pe_old_wave j=%0d got %0d exp %0d", j, bus_if.wave_out, exp_wave); end
            if (bus_if.wave_out !== DW'(j < 3 ? j : 5 - j)) begin errors++; $display("FAIL pe_old_seq j=%0d got %0d", j, bus_if.wave_out); end
        end
        checks++;
        if (bus_if.cfg_pending !== 1'b0 || bus_if.period_start !== 1'b1) begin
            errors++; $display("FAIL pe_second_apply pending=%0b ps=%0b exp 0/1", bus_if.cfg_pending, bus_if.period_start);
        end
        for (int j = 0; j < 16; j++) begin
            step(1, 0, 0, 0);
            checks++;
            if (bus_if.wave_out !== DW'(p_saw3[j % 8])) begin errors++; $display("FAIL pe_new_seq j=%0d got %0d exp %0d", j, bus_if.wave_out, p_saw3[j % 8]); end
        end
    endtask

    task automatic test_async_reset();
        step(1, 2, 5, 1);
        step(1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus_if.wave_out !== 8'd0) begin errors++; $display("FAIL arst_wave got %0d exp 0", bus_if.wave_out); end
        if (bus_if.cfg_pending !== 1'b0) begin errors++; $display("FAIL arst_pending got %0b exp 0", bus_if.cfg_pending); end
        if (bus_if.period_start !== 1'b0) begin errors++; $display("FAIL arst_ps got %0b exp 0", bus_if.period_start); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            step(1, 0, 0, 0);
            checks += 3;
            if (bus_if.wave_out !== exp_wave) begin errors++; $display("FAIL arst_run_wave k=%0d got %0d exp %0d", k, bus_if.wave_out, exp_wave); end
            if (bus_if.period_start !== exp_ps) begin errors++; $display("FAIL arst_run_ps k=%0d got %0b exp %0b", k, bus_if.period_start, exp_ps); end
            if (bus_if.cfg_pending !== 1'b0) begin errors++; $display("FAIL arst_run_pending k=%0d got %0b exp 0", k, bus_if.cfg_pending); end
        end
    endtask

    task automatic test_random();
        bit e, ld;
        int f, h;
        for (int k = 0; k < 3000; k++) begin
            e  = ($urandom_range(0, 9) < 8);
            ld = ($urandom_range(0, 19) == 0);
            f  = $urandom_range(0, 7);
            h  = $urandom_range(0, 15);
            step(e, f, h, ld);
            checks += 3;
            if (bus_if.wave_out !== exp_wave) begin errors++; $display("FAIL rnd_wave k=%0d got %0d exp %0d", k, bus_if.wave_out, exp_wave); end
            if (bus_if.period_start !== exp_ps) begin errors++; $display("FAIL rnd_ps k=%0d got %0b exp %0b", k, bus_if.period_start, exp_ps); end
            if (bus_if.cfg_pending !== m_pend) begin errors++; $display("FAIL rnd_pending k=%0d got %0b exp %0b", k, bus_if.cfg_pending, m_pend); end
        end
    endtask

    initial begin
        test_reset();
        test_square_default();
        test_functions();
        test_mute_strobe();
        test_freeze();
        test_cfg_at_period_end();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
